inst_fetch: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC unit. Accepts fetch

---
 rtl/inst_fetch.sv | 120 ++++++++++++
 tb/tb_inst_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// inst_fetch : fetch stage between PC unit and decode with in-order imem buffer
// Rev 1.0
// ============================================================================
module inst_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pc_valid_i,
  input  logic [ADDR_WIDTH-1:0] pc_addr_i,
  output logic                  pc_ready_o,
  input  logic                  flush_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  inst_valid_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  input  logic                  inst_ready_i,
  output logic                  err_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int DCW = CW + 4;
  localparam logic [CW:0] C_DEPTH = (CW + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] pend_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rsp_data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] rsp_addr_q [DEPTH];

  logic [PW-1:0]  pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic [PW-1:0]  rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [CW-1:0]  pend_cnt_q, pend_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic [DCW-1:0] drop_cnt_q, drop_cnt_d;
  logic           err_q, err_d;

  logic credit_ok;
  logic have_drop, have_pend;
  logic rv_drop, rv_live, rv_err;
  logic push_rsp, pop_rsp;

  // Credit is taken from registered counts only, so a same-cycle pop never frees a slot.
  assign credit_ok   = ({1'b0, pend_cnt_q} + {1'b0, rsp_cnt_q}) < C_DEPTH;
  assign imem_req_o  = pc_valid_i & credit_ok & ~flush_i;
  assign imem_addr_o = pc_addr_i;
  assign pc_ready_o  = imem_req_o & imem_gnt_i;

  assign have_drop = (drop_cnt_q != '0);
  assign have_pend = (pend_cnt_q != '0);
  assign rv_drop   = imem_rvalid_i & have_drop;
  assign rv_live   = imem_rvalid_i & ~have_drop & have_pend;
  assign rv_err    = imem_rvalid_i & ~have_drop & ~have_pend;

  assign push_rsp     = rv_live & ~flush_i;
  assign inst_valid_o = (rsp_cnt_q != '0);
  assign pop_rsp      = inst_valid_o & inst_ready_i & ~flush_i;
  assign inst_o       = inst_valid_o ? rsp_data_q[rsp_rd_q] : '0;
  assign inst_addr_o  = inst_valid_o ? rsp_addr_q[rsp_rd_q] : '0;
  assign err_o        = err_q;

  always_comb begin
    pend_wr_d  = pend_wr_q + PW'(pc_ready_o);
    pend_rd_d  = pend_rd_q + PW'(rv_live);
    pend_cnt_d = pend_cnt_q + CW'(pc_ready_o) - CW'(rv_live);
    rsp_wr_d   = rsp_wr_q + PW'(push_rsp);
    rsp_rd_d   = rsp_rd_q + PW'(pop_rsp);
    rsp_cnt_d  = rsp_cnt_q + CW'(push_rsp) - CW'(pop_rsp);
    drop_cnt_d = drop_cnt_q - DCW'(rv_drop);
    err_d      = err_q | rv_err;
    if (flush_i) begin
      // Live pending entries become anonymous drops; no grant can happen this cycle.
      pend_rd_d  = pend_wr_q;
      pend_cnt_d = '0;
      rsp_rd_d   = rsp_wr_q;
      rsp_cnt_d  = '0;
      drop_cnt_d = drop_cnt_q + DCW'(pend_cnt_q) - DCW'(rv_drop | rv_live);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
      pend_cnt_q <= '0;
      rsp_wr_q   <= '0;
      rsp_rd_q   <= '0;
      rsp_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
      pend_cnt_q <= pend_cnt_d;
      rsp_wr_q   <= rsp_wr_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_cnt_q  <= rsp_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pc_ready_o) begin
      pend_mem_q[pend_wr_q] <= pc_addr_i;
    end
    if (push_rsp) begin
      rsp_data_q[rsp_wr_q] <= imem_rdata_i;
      rsp_addr_q[rsp_wr_q] <= pend_mem_q[pend_rd_q];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch : randomized and directed bench for inst_fetch against a queue model
// Rev 1.0
// ============================================================================
module tb_inst_fetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pc_valid_i = 1'b0;
  logic [31:0] pc_addr_i = '0;
  logic        pc_ready_o;
  logic        flush_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i = 1'b0;
  logic        err_o;

  inst_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .pc_valid_i(pc_valid_i), .pc_addr_i(pc_addr_i), .pc_ready_o(pc_ready_o),
    .flush_i(flush_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .inst_ready_i(inst_ready_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: live pending addresses, buffered {data,addr}, anonymous drops, error flag.
  logic [31:0] m_pend[$];
  logic [63:0] m_rsp[$];
  int          m_drop = 0;
  bit          m_err = 1'b0;
  // Memory environment: every granted address, answered strictly in order.
  logic [31:0] mem_q[$];
  // Deliveries observed at decode, for directed literal checks.
  logic [31:0] del_addr[$];
  int          del_cyc[$];

  function automatic logic [31:0] hash(input logic [31:0] a);
    return a ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic compare(input bit pv, input bit fl, input bit g);
    bit          exp_req;
    bit          exp_iv;
    logic [63:0] head;
    exp_req = pv && ((m_pend.size() + m_rsp.size()) < DEPTH) && !fl;
    exp_iv  = (m_rsp.size() != 0);
    head    = exp_iv ? m_rsp[0] : 64'd0;
    check("imem_req", 64'(imem_req_o), 64'(exp_req));
    check("pc_ready", 64'(pc_ready_o), 64'(exp_req && g));
    if (exp_req) check("imem_addr", 64'(imem_addr_o), 64'(pc_addr_i));
    check("inst_valid", 64'(inst_valid_o), 64'(exp_iv));
    check("inst_data", 64'(inst_o), 64'(head[63:32]));
    check("inst_addr", 64'(inst_addr_o), 64'(head[31:0]));
    check("err", 64'(err_o), 64'(m_err));
    if (inst_valid_o && inst_ready_i) begin
      del_addr.push_back(inst_addr_o);
      del_cyc.push_back(cyc);
    end
  endtask

  task automatic model_update(input bit pv, input logic [31:0] a, input bit fl, input bit g,
                              input bit rv, input logic [31:0] rd, input bit rdy);
    bit          req;
    bit          pr;
    logic [31:0] a0;
    req = pv && ((m_pend.size() + m_rsp.size()) < DEPTH) && !fl;
    pr  = req && g;
    if (m_rsp.size() != 0 && rdy && !fl) void'(m_rsp.pop_front());
    if (rv) begin
      if (m_drop > 0) m_drop--;
      else if (m_pend.size() != 0) begin
        a0 = m_pend.pop_front();
        if (!fl) m_rsp.push_back({rd, a0});
      end else m_err = 1'b1;
    end
    if (fl) begin
      m_drop += m_pend.size();
      m_pend.delete();
      m_rsp.delete();
    end
    if (pr) m_pend.push_back(a);
    if (rv && mem_q.size() != 0) void'(mem_q.pop_front());
    if (pr) mem_q.push_back(a);
  endtask

  // rvsel: 0 = no rvalid, 1 = rvalid if memory has something outstanding, 2 = forced rvalid.
  task automatic step(input bit pv, input logic [31:0] a, input bit fl, input bit g,
                      input int rvsel, input bit rdy);
    bit          rv;
    logic [31:0] rd;
    @(negedge clk);
    rv = (rvsel == 2) || (rvsel == 1 && mem_q.size() != 0);
    rd = (mem_q.size() != 0) ? hash(mem_q[0]) : 32'hBAD0_BAD0;
    pc_valid_i = pv; pc_addr_i = a; flush_i = fl; imem_gnt_i = g;
    imem_rvalid_i = rv; imem_rdata_i = rd; inst_ready_i = rdy;
    #1;
    compare(pv, fl, g);
    model_update(pv, a, fl, g, rv, rd, rdy);
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pc_valid_i = 0; pc_addr_i = 0; flush_i = 0; imem_gnt_i = 0;
    imem_rvalid_i = 0; imem_rdata_i = 0; inst_ready_i = 0;
    reset_n = 1'b0;
    #1;
    check("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    check("rst_req", 64'(imem_req_o), 64'd0);
    check("rst_pc_ready", 64'(pc_ready_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_inst", {inst_o, inst_addr_o}, 64'd0);
    m_pend.delete(); m_rsp.delete(); mem_q.delete();
    m_drop = 0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int          c0;
    int          grants;
    logic [31:0] nxt;
    logic [31:0] held_inst;

    do_reset();

    // 1: zero-wait memory, back-to-back delivery
    del_addr.delete(); del_cyc.delete();
    c0 = cyc;
    step(1, 32'h0, 0, 1, 0, 1);
    step(1, 32'h4, 0, 1, 1, 1);
    step(1, 32'h8, 0, 1, 1, 1);
    drain(4);
    check("t1_count", 64'(del_addr.size()), 64'd3);
    if (del_addr.size() == 3) begin
      check("t1_a0", 64'(del_addr[0]), 64'h0);
      check("t1_a1", 64'(del_addr[1]), 64'h4);
      check("t1_a2", 64'(del_addr[2]), 64'h8);
      check("t1_lat", 64'(del_cyc[0] - c0), 64'd2);
      check("t1_b2b", 64'(del_cyc[2] - del_cyc[0]), 64'd2);
    end

    // 2: decode stalled -> credit limits grants to DEPTH, head held
    do_reset();
    grants = 0; nxt = 32'h100; held_inst = '0;
    for (int i = 0; i < 10; i++) begin
      step(1, nxt, 0, 1, 1, 0);
      if (pc_ready_o) begin grants++; nxt += 4; end
      if (i == 5) held_inst = inst_o;
    end
    check("t2_grants", 64'(grants), 64'(DEPTH));
    check("t2_held", 64'(inst_o), 64'(held_inst));
    check("t2_head_data", 64'(inst_o), 64'(hash(32'h100)));
    check("t2_head_addr", 64'(inst_addr_o), 64'h100);
    del_addr.delete(); del_cyc.delete();
    drain(8);
    check("t2_count", 64'(del_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < del_addr.size()) check("t2_order", 64'(del_addr[i]), 64'(32'h100 + 32'(4 * i)));

    // 3: grant withheld for three cycles
    do_reset();
    del_addr.delete(); del_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h40, 0, 0, 0, 1);
      check("t3_req", 64'(imem_req_o), 64'd1);
      check("t3_noready", 64'(pc_ready_o), 64'd0);
    end
    step(1, 32'h40, 0, 1, 0, 1);
    check("t3_ready", 64'(pc_ready_o), 64'd1);
    drain(4);
    check("t3_count", 64'(del_addr.size()), 64'd1);
    if (del_addr.size() == 1) check("t3_addr", 64'(del_addr[0]), 64'h40);

    // 4: flush with three fetches in flight
    do_reset();
    step(1, 32'h10, 0, 1, 0, 1);
    step(1, 32'h14, 0, 1, 0, 1);
    step(1, 32'h18, 0, 1, 0, 1);
    del_addr.delete(); del_cyc.delete();
    step(1, 32'h70, 1, 1, 0, 1);
    check("t4_flush_noreq", 64'(imem_req_o), 64'd0);
    step(1, 32'h80, 0, 1, 0, 1);
    drain(8);
    check("t4_count", 64'(del_addr.size()), 64'd1);
    if (del_addr.size() == 1) check("t4_addr", 64'(del_addr[0]), 64'h80);

    // 5: flush coinciding with a returning word
    do_reset();
    step(1, 32'h20, 0, 1, 0, 1);
    step(1, 32'h24, 0, 1, 0, 1);
    step(1, 32'h28, 0, 1, 0, 1);
    del_addr.delete(); del_cyc.delete();
    step(0, 32'h0, 1, 0, 1, 1);
    drain(3);
    step(1, 32'h90, 0, 1, 0, 1);
    drain(4);
    check("t5_count", 64'(del_addr.size()), 64'd1);
    if (del_addr.size() == 1) check("t5_addr", 64'(del_addr[0]), 64'h90);
    check("t5_err", 64'(err_o), 64'd0);

    // 6: spurious rvalid, then reset mid-operation
    do_reset();
    step(0, 32'h0, 0, 0, 2, 1);
    @(posedge clk); #1;
    check("t6_err", 64'(err_o), 64'd1);
    check("t6_novalid", 64'(inst_valid_o), 64'd0);
    step(1, 32'h50, 0, 1, 0, 0);
    step(0, 32'h0, 0, 0, 1, 0);
    @(posedge clk); #1;
    check("t6_valid", 64'(inst_valid_o), 64'd1);
    do_reset();

    // Randomized traffic against the model, with one reset in the middle
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) do_reset();
      step(1'($urandom_range(0, 3) != 0), $urandom() & 32'hFFFF_FFFC,
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 9) < 6),
           int'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7));
    end
    drain(20);
    check("end_err", 64'(err_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
